uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte-wide UART transmitter fed directly by the UART slave port of the memory bus: it consumes the 8-bit write data and single-cycle write strobe produced on the bus's UART decode.
- Written bytes are queued in a small FIFO and serialized 8N1, LSB first, on a single txd line using a fixed clock divider.
- Status outputs are provided so the core/bench can poll for space and detect dropped bytes.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (>=2); 100 MHz / 115200 baud.
FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
DATA_W, 8, bits per character; fixed at 8, exposed for the package constant only.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
wr_data  input  8  byte to transmit (bus write_data[7:0]).
wr_en  input  1  one-cycle write strobe (bus UART write enable).
txd  output  1  serial line, idle high.
busy  output  1  frame in progress or FIFO non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky: a write was dropped because the FIFO was full.
ovf_clr  input  1  one-cycle clear of overflow.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - txd=1, busy=0, fifo_full=0, fifo_empty=1, fifo_level=0, overflow=0.
  - FSM in IDLE; divider and bit counter cleared.
  - Reset mid-frame aborts the frame; txd returns high immediately, with no glitch low.
- Push:
  - wr_en=1 with fifo_full=0 stores wr_data at the write pointer on that edge.
  - wr_en=1 with fifo_full=1 drops the byte and sets overflow on that edge.
  - Full is judged on the registered level, even if a pop happens in the same cycle.
- Pop: FSM in IDLE with fifo_empty=0 pops the head into the shift register and enters START on the same edge.
- Simultaneous push and pop: level is unchanged; both pointers advance.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally; the level counter is the full/empty source of truth.
- FSM:
  - IDLE -> START (pop).
  - START: txd=0 for CLK_DIV cycles -> DATA.
  - DATA: txd=shift[0], shift right every CLK_DIV cycles, 8 bits, bit counter 0..7 -> STOP.
  - STOP: txd=1 for CLK_DIV cycles -> IDLE.
  - txd is registered.
- Divider: counts 0..CLK_DIV-1; the bit boundary is at CLK_DIV-1; reloads to 0 on each FSM transition.
- Latency: a write into an empty FIFO while IDLE is stored on edge E; the pop occurs on E+1; txd goes low on E+1 (registered with the pop).
- Frame length: exactly 10*CLK_DIV cycles from the txd falling edge to the next possible start.
- Back-to-back: with the FIFO non-empty, STOP->IDLE->START costs 1 extra idle cycle; the inter-frame gap is 1 clock.
- busy = (state!=IDLE) | !fifo_empty.
- overflow cleared by ovf_clr; if ovf_clr and a new overflow coincide, set wins.

Optional Feature:
- UART_TX_PARITY_EN defined: adds a PARITY state between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame becomes 11*CLK_DIV cycles.
- Undefined: 8N1 only; no parity logic or state encoding is synthesized.

Decomposition:
- Shared package uart_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants UART_DATA_W=8, UART_DEFAULT_CLK_DIV=868, UART_BUS_BASE='h100.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports push, pop, din, dout, full, empty, level.
  - Head is available combinationally on dout.
  - Reusable elsewhere on the memory bus.

Test Plan:
- Reset then idle 100 cycles -> txd stays 1, fifo_empty=1, busy=0, overflow=0.
- CLK_DIV=4, write 0xA5 -> txd low at E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; total 40 cycles; busy drops after stop.
- CLK_DIV=4, FIFO_DEPTH=4, write 0x01..0x05 in consecutive cycles -> 0x01 popped immediately, 0x02..0x05 fill the FIFO, none dropped, overflow=0; a sixth write 0x06 next cycle -> fifo_full=1, byte dropped, overflow=1; line shows 0x01..0x05 each separated by 1 idle cycle.
- Overflow set, then ovf_clr coincident with another full write -> overflow stays 1; ovf_clr alone next cycle -> overflow=0.
- Assert rst_n low mid-DATA of 0x3C -> txd=1 asynchronously, fifo_level=0; after release, write 0x55 -> a clean, complete frame of 0x55.
- With UART_TX_PARITY_EN, write 0x07 (three ones) -> parity bit txd=1 before stop; write 0x03 -> parity bit 0; frame = 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_pkg : shared UART constants, transmitter state encoding and helpers  |
// | Optional macro UART_TX_PARITY_EN adds the PARITY state.  Revision: 1.0    |
// +---------------------------------------------------------------------------+
package uart_pkg;

   localparam int          UART_DATA_W          = 8;
   localparam int          UART_DEFAULT_CLK_DIV = 868;
   localparam logic [11:0] UART_BUS_BASE        = 12'h100;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
`endif

   function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, head visible combinationally on dout       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_lw = c_aw + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_lw-1:0]  r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   // The level counter, not the pointers, decides full/empty.
   assign full      = (r_level == c_lw'(DEPTH));
   assign empty     = (r_level == '0);
   assign level     = r_level;
   assign dout      = r_mem[r_rd_ptr];
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + c_lw'(1);
            2'b01:   r_level <= r_level - c_lw'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_tx_fifo : bus-fed byte FIFO plus 8N1 serializer with fixed divider   |
// | Optional macro UART_TX_PARITY_EN adds an even-parity bit.  Revision: 1.0  |
// +---------------------------------------------------------------------------+
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = UART_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          wr_en,
   output logic                          txd,
   output logic                          busy,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int c_sw     = $bits(tx_state_t);
   localparam int c_div_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_bit_w  = $clog2(DATA_W);

   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
   localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(DATA_W - 1);

   localparam logic [c_sw-1:0] S_IDLE   = IDLE;
   localparam logic [c_sw-1:0] S_START  = START;
   localparam logic [c_sw-1:0] S_DATA   = DATA;
   localparam logic [c_sw-1:0] S_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
   localparam logic [c_sw-1:0] S_PARITY = PARITY;
`endif

   logic [c_sw-1:0]    r_state;
   logic [c_div_w-1:0] r_div;
   logic [c_bit_w-1:0] r_bit_cnt;
   logic [DATA_W-1:0]  r_shift;
   logic               r_txd;
   logic               r_overflow;
`ifdef UART_TX_PARITY_EN
   logic               r_par;
`endif
   logic [DATA_W-1:0]  w_head;
   logic               w_pop;
   logic               w_bit_end;

   assign w_pop     = (r_state == S_IDLE) && !fifo_empty;
   assign w_bit_end = (r_div == c_div_max);
   assign txd       = r_txd;
   assign busy      = (r_state != S_IDLE) || !fifo_empty;
   assign overflow  = r_overflow;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .pop   (w_pop),
      .din   (wr_data),
      .dout  (w_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // A new overflow takes priority over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (wr_en && fifo_full) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   // txd is registered together with each state change, so the line leads
   // the state by nothing and the start bit appears on the pop edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  r_state <= S_START;
                  r_div   <= '0;
                  r_shift <= w_head;
                  r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  r_par   <= even_parity(w_head);
`endif
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_div     <= '0;
                  r_bit_cnt <= '0;
                  r_txd     <= r_shift[0];
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_div <= '0;
                  if (r_bit_cnt == c_bit_max) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_txd   <= r_par;
`else
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_shift   <= r_shift >> 1;
                     r_txd     <= r_shift[1];
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_div   <= '0;
                  r_txd   <= 1'b1;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_state <= S_IDLE;
                  r_div   <= '0;
                  r_txd   <= 1'b1;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_div   <= '0;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed + random checks of uart_tx_fifo via line decode|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_uart_tx_fifo;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB      = 11;
`else
   localparam int NB      = 10;
`endif
   localparam int FRAME   = NB * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       ovf_clr;
   logic       txd;
   logic       busy;
   logic       fifo_full;
   logic       fifo_empty;
   logic [2:0] fifo_level;
   logic       overflow;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   uart_tx_fifo #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH),
      .DATA_W     (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .txd        (txd),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: rebuilds each frame from txd and records whether every
   // bit was steady for its whole period with correct framing bits.
   logic [7:0]    rx_data_q  [$];
   logic          rx_ok_q    [$];
   int            rx_start_q [$];
   logic          dec_active = 1'b0;
   int            dec_pos;
   int            dec_start;
   logic          dec_clean;
   logic [NB-1:0] dec_bits;

   always @(negedge clk) begin
      if (!rst_n) begin
         dec_active = 1'b0;
      end else if (dec_active) begin
         if (dec_pos % CLK_DIV == 0) dec_bits[dec_pos / CLK_DIV] = txd;
         else if (txd !== dec_bits[dec_pos / CLK_DIV]) dec_clean = 1'b0;
         dec_pos++;
         if (dec_pos == FRAME) begin
            rx_data_q.push_back(dec_bits[8:1]);
`ifdef UART_TX_PARITY_EN
            rx_ok_q.push_back(dec_clean && !dec_bits[0] && dec_bits[NB-1] &&
                              (dec_bits[9] == ^dec_bits[8:1]));
`else
            rx_ok_q.push_back(dec_clean && !dec_bits[0] && dec_bits[NB-1]);
`endif
            rx_start_q.push_back(dec_start);
            dec_active = 1'b0;
         end
      end else if (txd === 1'b0) begin
         dec_active = 1'b1;
         dec_pos    = 1;
         dec_bits   = '0;
         dec_clean  = 1'b1;
         dec_start  = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic c);
      wr_en   = w;
      wr_data = d;
      ovf_clr = c;
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((busy || dec_active) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic clear_rx();
      rx_data_q.delete();
      rx_ok_q.delete();
      rx_start_q.delete();
   endtask

   // Every frame in the queue must match the written byte and be clean;
   // frames of one burst follow each other with exactly one idle clock.
   task automatic check_frames(input string tag, input logic [7:0] exp_q [$], input int first_start);
      check({tag, "_count"}, 32'(rx_data_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < rx_data_q.size(); k++) begin
         check({tag, "_data"}, 32'(rx_data_q[k]), 32'(exp_q[k]));
         check({tag, "_ok"},   32'(rx_ok_q[k]),   32'd1);
         if (k == 0) check({tag, "_start"}, 32'(rx_start_q[0]), 32'(first_start));
         else check({tag, "_gap"}, 32'(rx_start_q[k] - rx_start_q[k-1]), 32'(FRAME + 1));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_q [$];
      int         ce;
      int         len;
      int         acc;
      logic [7:0] b;

      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd",   32'(txd),        32'd1);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_full",  32'(fifo_full),  32'd0);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ovf",   32'(overflow),   32'd0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_txd",    32'(txd),              32'd1);
      check("idle_empty",  32'(fifo_empty),       32'd1);
      check("idle_busy",   32'(busy),             32'd0);
      check("idle_ovf",    32'(overflow),         32'd0);
      check("idle_frames", 32'(rx_data_q.size()), 32'd0);

      // Single byte: start on the edge after the write, exact frame length.
      clear_rx();
      drive(1'b1, 8'hA5, 1'b0);
      wr_en = 1'b0;
      ce = cyc;
      repeat (FRAME) @(negedge clk);
      check("a5_busy_stop", 32'(busy), 32'd1);
      @(negedge clk);
      check("a5_busy_end", 32'(busy), 32'd0);
      check("a5_txd_end",  32'(txd),  32'd1);
      exp_q = '{8'hA5};
      check_frames("a5", exp_q, ce + 1);

      // Burst of six into a depth-4 FIFO: first pops at once, sixth drops.
      clear_rx();
      drive(1'b1, 8'h01, 1'b0);
      ce = cyc;
      drive(1'b1, 8'h02, 1'b0);
      drive(1'b1, 8'h03, 1'b0);
      drive(1'b1, 8'h04, 1'b0);
      drive(1'b1, 8'h05, 1'b0);
      check("burst_full",  32'(fifo_full),  32'd1);
      check("burst_level", 32'(fifo_level), 32'd4);
      check("burst_ovf0",  32'(overflow),   32'd0);
      drive(1'b1, 8'h06, 1'b0);
      check("burst_ovf1",  32'(overflow),   32'd1);
      check("burst_lvl6",  32'(fifo_level), 32'd4);
      drive(1'b1, 8'h07, 1'b1);
      check("ovf_set_wins", 32'(overflow), 32'd1);
      drive(1'b0, 8'h00, 1'b1);
      check("ovf_clr", 32'(overflow), 32'd0);
      drive(1'b0, 8'h00, 1'b0);
      drain("burst_drain");
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_frames("burst", exp_q, ce + 1);

      // Reset during a data bit: line returns high without waiting for a clock.
      clear_rx();
      drive(1'b1, 8'h3C, 1'b0);
      wr_en = 1'b0;
      repeat (CLK_DIV + 2) @(negedge clk);
      check("pre_rst_txd", 32'(txd), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_txd",   32'(txd),        32'd1);
      check("async_level", 32'(fifo_level), 32'd0);
      check("async_busy",  32'(busy),       32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_frames", 32'(rx_data_q.size()), 32'd0);
      drive(1'b1, 8'h55, 1'b0);
      wr_en = 1'b0;
      ce = cyc;
      drain("r55_drain");
      exp_q = '{8'h55};
      check_frames("r55", exp_q, ce + 1);

`ifdef UART_TX_PARITY_EN
      clear_rx();
      drive(1'b1, 8'h07, 1'b0);
      ce = cyc;
      drive(1'b1, 8'h03, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      drain("par_drain");
      exp_q = '{8'h07, 8'h03};
      check_frames("par", exp_q, ce + 1);
`endif

      // Random bursts: accepted bytes are the first DEPTH+1, the rest drop.
      for (int it = 0; it < 5; it++) begin
         clear_rx();
         exp_q.delete();
         len = $urandom_range(1, 7);
         acc = (len > DEPTH + 1) ? DEPTH + 1 : len;
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            if (k < acc) exp_q.push_back(b);
            drive(1'b1, b, 1'b0);
            if (k == 0) ce = cyc;
         end
         drive(1'b0, 8'h00, 1'b0);
         check("rnd_ovf", 32'(overflow), 32'(len > DEPTH + 1));
         drain("rnd_drain");
         check_frames("rnd", exp_q, ce + 1);
         drive(1'b0, 8'h00, 1'b1);
         drive(1'b0, 8'h00, 1'b0);
         check("rnd_ovf_clr", 32'(overflow), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
